// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_pkg
//  Brief    : Shared floor-code widths and dispatcher state encoding.
//  Revision : 1.0
// ============================================================================
package elevator_pkg;

    localparam int              FLOOR_W = 3;
    localparam logic [FLOOR_W-1:0] NO_REQ = 3'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_GAP   = ST_GAP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_select.sv
`default_nettype none
// ============================================================================
//  Module   : scan_select
//  Brief    : SCAN target picker: nearest pending floor in the travel
//             direction, otherwise the nearest one behind.
//  Revision : 1.0
// ============================================================================
module scan_select
    import elevator_pkg::*;
#(
    parameter int MAX_FLOOR = 5
) (
    input  logic [MAX_FLOOR-1:0] pending,
    input  logic [FLOOR_W-1:0]   cur_floor,
    input  logic                 direction,
    output logic [FLOOR_W-1:0]   sel,
    output logic                 sel_valid
);

    logic [FLOOR_W-1:0]   w_eff;
    logic [MAX_FLOOR-1:0] w_above;
    logic [MAX_FLOOR-1:0] w_below;
    logic [FLOOR_W-1:0]   w_lo_at [MAX_FLOOR:0];
    logic [FLOOR_W-1:0]   w_hi_at [MAX_FLOOR:0];
    logic [FLOOR_W-1:0]   w_lowest_above;
    logic [FLOOR_W-1:0]   w_highest_below;

    // An out-of-range position behaves as if the car sits below floor 1.
    assign w_eff = (cur_floor > FLOOR_W'(MAX_FLOOR)) ? NO_REQ : cur_floor;

    assign w_lo_at[MAX_FLOOR] = NO_REQ;
    assign w_hi_at[0]         = NO_REQ;

    generate
        for (genvar g = 0; g < MAX_FLOOR; g++) begin : g_floor
            assign w_above[g]   = pending[g] && (FLOOR_W'(g + 1) > w_eff);
            assign w_below[g]   = pending[g] && (FLOOR_W'(g + 1) < w_eff);
            assign w_lo_at[g]   = w_above[g] ? FLOOR_W'(g + 1) : w_lo_at[g + 1];
            assign w_hi_at[g+1] = w_below[g] ? FLOOR_W'(g + 1) : w_hi_at[g];
        end
    endgenerate

    assign w_lowest_above  = w_lo_at[0];
    assign w_highest_below = w_hi_at[MAX_FLOOR];

    always_comb begin
        sel = NO_REQ;
        if (direction) begin
            sel = (w_lowest_above != NO_REQ) ? w_lowest_above : w_highest_below;
        end else begin
            sel = (w_highest_below != NO_REQ) ? w_highest_below : w_lowest_above;
        end
        sel_valid = (sel != NO_REQ);
    end

endmodule
`default_nettype wire

// File: rtl/floor_request_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : floor_request_dispatcher
//  Brief    : Latches call buttons, issues one-cycle floor requests to the
//             elevator and re-issues them on an arrival timeout.
//  Revision : 1.0
// ============================================================================
module floor_request_dispatcher
    import elevator_pkg::*;
#(
    parameter int MAX_FLOOR = 5,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MAX_FLOOR-1:0] btn,
    input  logic [FLOOR_W-1:0]   cur_floor,
    input  logic                 direction,
    input  logic                 arrive,
    output logic [FLOOR_W-1:0]   from,
    output logic [MAX_FLOOR-1:0] pending,
    output logic [FLOOR_W-1:0]   target,
    output logic                 busy,
    output logic                 served
);

    state_t               r_state, w_state_nxt;
    logic [MAX_FLOOR-1:0] r_pending, w_pending_nxt;
    logic [FLOOR_W-1:0]   r_from, w_from_nxt;
    logic [FLOOR_W-1:0]   r_target, w_target_nxt;
    logic                 r_busy;
    logic                 r_served, w_served_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;

    logic [MAX_FLOOR-1:0] w_cur_mask;
    logic [MAX_FLOOR-1:0] w_tgt_mask;
    logic [MAX_FLOOR-1:0] w_clear;
    logic                 w_cur_hit;
    logic [FLOOR_W-1:0]   w_sel;
    logic                 w_sel_valid;

    scan_select #(
        .MAX_FLOOR (MAX_FLOOR)
    ) u_scan_select (
        .pending   (r_pending),
        .cur_floor (cur_floor),
        .direction (direction),
        .sel       (w_sel),
        .sel_valid (w_sel_valid)
    );

    // Out-of-range floor codes match no bit, so they never clear anything.
    generate
        for (genvar g = 0; g < MAX_FLOOR; g++) begin : g_floor_mask
            assign w_cur_mask[g] = (cur_floor == FLOOR_W'(g + 1));
            assign w_tgt_mask[g] = (r_target  == FLOOR_W'(g + 1));
        end
    endgenerate

    assign w_cur_hit = |(r_pending & w_cur_mask);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_from_nxt   = NO_REQ;
        w_target_nxt = r_target;
        w_served_nxt = 1'b0;
        w_cnt_nxt    = r_cnt;
        w_clear      = '0;

        case (r_state)
            S_IDLE: begin
                if (w_cur_hit) begin
                    w_clear      = w_cur_mask;
                    w_served_nxt = 1'b1;
                end else if (w_sel_valid) begin
                    w_state_nxt  = S_ISSUE;
                    w_target_nxt = w_sel;
                    w_from_nxt   = w_sel;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = '0;
            end
            S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (arrive && (cur_floor == r_target)) begin
                    w_clear      = w_tgt_mask;
                    w_served_nxt = 1'b1;
                    w_state_nxt  = S_GAP;
                    w_target_nxt = NO_REQ;
                end else begin
                    if (arrive && w_cur_hit) begin
                        w_clear      = w_cur_mask;
                        w_served_nxt = 1'b1;
                    end
                    // Same target is re-issued; the pending set is not rescanned.
                    if (w_cnt_inc == CNT_W'(TIMEOUT - 1)) begin
                        w_state_nxt = S_ISSUE;
                        w_from_nxt  = r_target;
                    end
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_target_nxt = NO_REQ;
            end
        endcase

        w_pending_nxt = (r_pending & ~w_clear) | btn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_from    <= NO_REQ;
            r_target  <= NO_REQ;
            r_busy    <= 1'b0;
            r_served  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_from    <= w_from_nxt;
            r_target  <= w_target_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_served  <= w_served_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign from    = r_from;
    assign pending = r_pending;
    assign target  = r_target;
    assign busy    = r_busy;
    assign served  = r_served;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_floor_request_dispatcher
//  Brief    : Directed scenarios plus random traffic against a floor-level
//             behavioural model of the dispatcher.
//  Revision : 1.0
// ============================================================================
module tb_floor_request_dispatcher;

    localparam int MAXF = 5;
    localparam int TMO  = 8;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [MAXF-1:0] btn;
    logic [2:0]      cur_floor;
    logic            direction;
    logic            arrive;
    logic [2:0]      from;
    logic [MAXF-1:0] pending;
    logic [2:0]      target;
    logic            busy;
    logic            served;

    always #5 clk = ~clk;

    floor_request_dispatcher #(
        .MAX_FLOOR (MAXF),
        .TIMEOUT   (TMO),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .cur_floor (cur_floor),
        .direction (direction),
        .arrive    (arrive),
        .from      (from),
        .pending   (pending),
        .target    (target),
        .busy      (busy),
        .served    (served)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model: which floor the car was sent to, how long ago the request went
    // out, and whether the mandatory quiet cycle after an arrival is running.
    logic [MAXF-1:0] m_pend;
    int              m_from, m_target, m_age;
    bit              m_busy, m_served, m_active, m_gap;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit floor_ok(input int f);
        return (f >= 1) && (f <= MAXF);
    endfunction

    function automatic int pick(input logic [MAXF-1:0] p, input int cur, input bit up);
        int eff   = floor_ok(cur) ? cur : 0;
        int above = 0;
        int below = 0;
        for (int f = 1; f <= MAXF; f++) begin
            if (p[f-1] && f > eff && above == 0) above = f;
            if (p[f-1] && f < eff)               below = f;
        end
        if (up) return (above != 0) ? above : below;
        return (below != 0) ? below : above;
    endfunction

    task automatic model_step();
        logic [MAXF-1:0] clr;
        int cur;
        bit srv;
        int f;
        clr = '0;
        srv = 1'b0;
        f   = 0;
        cur = int'(cur_floor);
        if (reset) begin
            m_pend = '0; m_from = 0; m_target = 0; m_age = 0;
            m_busy = 0; m_served = 0; m_active = 0; m_gap = 0;
            return;
        end
        if (m_gap) begin
            m_gap = 0;
        end else if (!m_active) begin
            if (floor_ok(cur) && m_pend[cur-1]) begin
                clr[cur-1] = 1'b1;
                srv = 1'b1;
            end else if (m_pend != '0) begin
                m_target = pick(m_pend, cur, direction);
                m_active = 1;
                m_age    = 0;
                f        = m_target;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            if (arrive && cur == m_target) begin
                clr[m_target-1] = 1'b1;
                srv      = 1'b1;
                m_active = 0;
                m_gap    = 1;
                m_target = 0;
            end else begin
                if (arrive && floor_ok(cur) && m_pend[cur-1]) begin
                    clr[cur-1] = 1'b1;
                    srv = 1'b1;
                end
                m_age++;
                if (m_age == TMO) begin
                    f     = m_target;
                    m_age = 0;
                end
            end
        end
        m_pend   = (m_pend & ~clr) | btn;
        m_from   = f;
        m_served = srv;
        m_busy   = m_active || m_gap;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("from",    int'(from),    m_from);
        check("pending", int'(pending), int'(m_pend));
        check("target",  int'(target),  m_target);
        check("busy",    int'(busy),    int'(m_busy));
        check("served",  int'(served),  int'(m_served));
    endtask

    initial begin
        reset = 1'b1; btn = '0; cur_floor = 3'd1; direction = 1'b1; arrive = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("idle_from", int'(from), 0);
        check("idle_busy", int'(busy), 0);

        // Single call from floor 1 to floor 5.
        btn = 5'b10000; cycle();
        check("latch5", int'(pending), 16);
        btn = '0; cycle();
        check("issue5_from", int'(from), 5);
        check("issue5_tgt", int'(target), 5);
        check("issue5_busy", int'(busy), 1);
        cycle();
        check("issue5_once", int'(from), 0);
        cycle(); cycle();
        cur_floor = 3'd5; arrive = 1'b1; cycle();
        check("arr5_served", int'(served), 1);
        check("arr5_pend", int'(pending), 0);
        arrive = 1'b0; cycle();
        check("gap_done_busy", int'(busy), 0);

        // SCAN ordering from floor 3 with calls at 1, 4, 5.
        cur_floor = 3'd3; direction = 1'b1; btn = 5'b11001; cycle();
        btn = '0; cycle();
        check("scan_first", int'(from), 4);
        cycle();
        cur_floor = 3'd4; arrive = 1'b1; cycle();
        arrive = 1'b0; cycle();
        cycle();
        check("scan_second", int'(from), 5);
        cycle();
        cur_floor = 3'd5; arrive = 1'b1; cycle();
        arrive = 1'b0; direction = 1'b0; cycle();
        cycle();
        check("scan_third", int'(from), 1);
        cycle();
        cur_floor = 3'd1; arrive = 1'b1; cycle();
        arrive = 1'b0; cycle();

        // Call at the floor the car is already on.
        cur_floor = 3'd2; direction = 1'b1; btn = 5'b00010; cycle();
        btn = '0; cycle();
        check("same_served", int'(served), 1);
        check("same_pend", int'(pending), 0);
        check("same_from", int'(from), 0);
        cycle();

        // Timeout re-issue, twice.
        cur_floor = 3'd1; btn = 5'b00100; cycle();
        btn = '0; cycle();
        check("tmo_issue0", int'(from), 3);
        for (int r = 1; r <= 2; r++) begin
            for (int k = 0; k < TMO - 1; k++) cycle();
            cycle();
            check("tmo_reissue", int'(from), 3);
        end
        cycle();
        cur_floor = 3'd3; arrive = 1'b1; cycle();
        arrive = 1'b0; cycle();

        // Opportunistic stop, then a press that collides with the final clear.
        cur_floor = 3'd1; direction = 1'b1; btn = 5'b10000; cycle();
        btn = '0; cycle();
        btn = 5'b00100; cycle();
        btn = '0; cur_floor = 3'd3; arrive = 1'b1; cycle();
        check("opp_pend", int'(pending), 16);
        check("opp_served", int'(served), 1);
        check("opp_target", int'(target), 5);
        check("opp_busy", int'(busy), 1);
        cur_floor = 3'd5; btn = 5'b10000; cycle();
        check("setwins_pend", int'(pending), 16);
        check("setwins_served", int'(served), 1);
        btn = '0; arrive = 1'b0; cycle();
        cycle();
        check("setwins_clear", int'(pending), 0);

        // Reset while waiting drops the target silently.
        cur_floor = 3'd4; btn = 5'b00010; cycle();
        btn = '0; cycle(); cycle();
        reset = 1'b1; cycle();
        check("rst_wait_served", int'(served), 0);
        check("rst_wait_busy", int'(busy), 0);
        reset = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            btn = '0;
            for (int b = 0; b < MAXF; b++)
                if ($urandom_range(0, 19) == 0) btn[b] = 1'b1;
            direction = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) cur_floor = 3'($urandom_range(1, MAXF));
            else                           cur_floor = 3'($urandom_range(0, 7));
            arrive = ($urandom_range(0, 3) == 0);
            if (arrive && m_target != 0 && $urandom_range(0, 1) == 1)
                cur_floor = 3'(m_target);
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floor_request_dispatcher.md
Name: floor_request_dispatcher

Overview:
- Upstream stage of the elevator controller.
- Latches per-floor call buttons into a pending set and picks the next target floor with a SCAN (same-direction-first) policy.
- Drives the elevator's 3-bit `from` request input with a one-cycle floor code, then waits for the elevator to report arrival before dispatching again.
- Re-issues the request if the elevator does not arrive within a timeout.

Parameters:
- MAX_FLOOR, 5: highest valid floor. Floors are 1..MAX_FLOOR; code 0 means "no request". Legal range 2..7.
- TIMEOUT, 64: cycles to wait in WAIT before re-issuing the same target. Must be ≥ 2.
- CNT_W, 7: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn  in  MAX_FLOOR  level call buttons; bit i-1 = floor i. Sampled every cycle.
- cur_floor  in  3  elevator's current floor.
- direction  in  1  elevator travel direction, 1 = up, 0 = down.
- arrive  in  1  one-cycle pulse from the elevator: stopped at cur_floor.
- from  out  3  request code to the elevator; nonzero for exactly one cycle per issue.
- pending  out  MAX_FLOOR  latched outstanding requests, same bit mapping as btn.
- target  out  3  floor currently being served; 0 when none.
- busy  out  1  high in ISSUE, WAIT and GAP.
- served  out  1  one-cycle pulse when a pending floor is cleared.

Behaviour:
- Reset values: pending=0, from=0, target=0, busy=0, served=0, counter=0, state=IDLE. Reset asserted mid-WAIT abandons the target with no served pulse.
- Latching: pending_next = (pending & ~clear) | btn. A press and a clear of the same bit in one cycle leave the bit set (set wins).
- States are IDLE, ISSUE, WAIT, GAP. All outputs are registered.
- IDLE, pending bit at cur_floor set: clear it, pulse served, stay in IDLE. This takes priority over selection.
- IDLE, otherwise with pending≠0: select sel and go to ISSUE with target=sel.
- Selection when direction=1: lowest pending floor > cur_floor; if none, highest pending floor < cur_floor.
- Selection when direction=0: mirror of the above (highest below, else lowest above).
- ISSUE: from=target for this cycle only; counter cleared. Next state WAIT.
- WAIT: from=0; counter increments.
  - arrive=1 and cur_floor==target: clear pending[target], pulse served, go to GAP.
  - arrive=1 at any other floor: that floor's pending bit is also cleared, with a served pulse (opportunistic stop). Remain in WAIT.
  - counter reaches TIMEOUT-1 with no matching arrive: go to ISSUE and re-issue the same target. Re-selection is not performed.
- GAP: one idle cycle, target=0, then IDLE. This guarantees from=0 for at least one cycle between issues.
- Latency: button press to from pulse is 2 cycles minimum (latch cycle, then IDLE→ISSUE).
- btn bits are sampled in every state, including WAIT.
- cur_floor=0 or cur_floor>MAX_FLOOR: treated as below floor 1 for selection; no same-floor clear.
- Widths: all floor comparisons are unsigned 3-bit. The counter saturates and never wraps.

Decomposition:
- Shared package elevator_pkg holds:
  - state encoding constants ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_GAP=3;
  - FLOOR_W=3;
  - NO_REQ=3'd0.
- One combinational sub-module, scan_select: inputs pending, cur_floor, direction; outputs sel (3-bit) and sel_valid.
- The FSM, pending register and timeout counter stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with btn=0 → from=0, pending=0, busy=0 on every cycle for 10 cycles.
- cur_floor=1, direction=1, btn=5'b10000 for 1 cycle → pending=5'b10000 next cycle; from=3'd5 for exactly one cycle 2 cycles after the press; busy=1; target=5. After arrive with cur_floor=5 → served pulses, pending=0, IDLE after GAP.
- cur_floor=3, direction=1, pending floors {1,4,5} → first issue from=4; after arrive at 4, with direction still 1 → from=5; then with direction=0 at floor 5 → from=1.
- cur_floor=2 idle, btn floor 2 pressed → pending bit cleared the cycle after latch, served=1, from never nonzero.
- TIMEOUT=8, issue to floor 3 with no arrive → from=3 re-pulses exactly 8 cycles after the first ISSUE cycle, and again 8 cycles later.
- In WAIT for floor 5, arrive at floor 3 with pending floor 3 set → pending[3] cleared, served pulses, state stays WAIT, target=5. Separately: btn for floor 5 held high during the matching arrive → pending[5] remains 1 (set wins).
